// File: rtl/rrf_mt.sv
// rrf_mt: two-thread banked register file with multi-port read/write, same-cycle write bypass and a bank clear sequencer
// Ports:
//   clk, rst                                       clock, asynchronous active-high reset
//   read_clkEn                                     capture enable for read_addr/read_oe/read_thread
//   read_addr, read_oe, read_thread                per-port read address, output enable, shared bank select
//   read_data                                      per-port read data, one cycle after capture, write-bypassed
//   write_addr, write_data, write_wen, write_thread  per-port writes into one bank per cycle
//   clear_req, clear_thread                        pulse to zero a whole bank, one entry per cycle
//   clear_busy                                     high while the clear sequence runs
`ifndef ALU_WIDTH
`define ALU_WIDTH 32
`endif
module rrf_mt #(
    parameter int DATA_WIDTH = `ALU_WIDTH,
    parameter int DEPTH      = 48,
    parameter int ADDR_WIDTH = 6,
    parameter int NREAD      = 9,
    parameter int NWRITE     = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read_clkEn,
    input  logic [NREAD*ADDR_WIDTH-1:0]  read_addr,
    input  logic [NREAD-1:0]             read_oe,
    input  logic                         read_thread,
    output logic [NREAD*DATA_WIDTH-1:0]  read_data,
    input  logic [NWRITE*ADDR_WIDTH-1:0] write_addr,
    input  logic [NWRITE*DATA_WIDTH-1:0] write_data,
    input  logic [NWRITE-1:0]            write_wen,
    input  logic                         write_thread,
    input  logic                         clear_req,
    input  logic                         clear_thread,
    output logic                         clear_busy
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_d;
    logic                    cthr, cthr_d;
    logic [DATA_WIDTH-1:0]   mem [2][DEPTH];
    logic                    hit [2][DEPTH];
    logic [DATA_WIDTH-1:0]   val [2][DEPTH];
    logic [NREAD*ADDR_WIDTH-1:0] ra_q;
    logic [NREAD-1:0]        oe_q;
    logic                    thr_q;

    assign clear_busy = state == CLEAR;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cthr_d  = cthr;
        if (state == IDLE && clear_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
            cthr_d  = clear_thread;
        end else if (state == CLEAR) begin
            state_d = cnt == LAST ? IDLE : CLEAR;
            cnt_d   = cnt == LAST ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cthr  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            cthr  <= cthr_d;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ra_q  <= '0;
            oe_q  <= '0;
            thr_q <= 1'b0;
        end else if (read_clkEn) begin
            ra_q  <= read_addr;
            oe_q  <= read_oe;
            thr_q <= read_thread;
        end

    // Per-entry write resolution: clear is lowest priority, then ports in
    // ascending index so the highest-index port overrides. Out-of-range
    // addresses never match an entry and are dropped.
    always_comb begin
        for (int b = 0; b < 2; b++)
            for (int e = 0; e < DEPTH; e++) begin
                hit[b][e] = clear_busy && cthr == 1'(b) && cnt == ADDR_WIDTH'(e);
                val[b][e] = '0;
                for (int p = 0; p < NWRITE; p++)
                    if (write_wen[p] && write_thread == 1'(b) &&
                        write_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e)) begin
                        hit[b][e] = 1'b1;
                        val[b][e] = write_data[p*DATA_WIDTH +: DATA_WIDTH];
                    end
            end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int e = 0; e < DEPTH; e++)
                    mem[b][e] <= '0;
        end else begin
            for (int b = 0; b < 2; b++)
                for (int e = 0; e < DEPTH; e++)
                    if (hit[b][e])
                        mem[b][e] <= val[b][e];
        end

    // Reads see this cycle's winning write (port or clear) before it lands.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        assign a = ra_q[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign read_data[i*DATA_WIDTH +: DATA_WIDTH] =
            (oe_q[i] && {1'b0, a} < DEPTH_W) ? (hit[thr_q][a] ? val[thr_q][a] : mem[thr_q][a]) : '0;
    end
endmodule

// File: tb/tb_rrf_mt.sv
// tb_rrf_mt: randomized and directed self-checking bench for rrf_mt against a behavioural model
module tb_rrf_mt;
    localparam int DW = 32, D = 48, AW = 6, NR = 9, NW = 9;

    logic clk = 0, rst = 0;
    logic read_clkEn = 0;
    logic [NR*AW-1:0] ra = '0;
    logic [NR-1:0] roe = '0;
    logic rthr = 0;
    logic [NR*DW-1:0] read_data;
    logic [NW*AW-1:0] wa = '0;
    logic [NW*DW-1:0] wd = '0;
    logic [NW-1:0] wen = '0;
    logic wthr = 0;
    logic clear_req = 0, clear_thread = 0, clear_busy;

    int checks = 0, failures = 0;

    logic [DW-1:0] m [2][D];
    logic [DW-1:0] nxt [2][D];
    int mra [NR];
    logic [NR-1:0] moe;
    logic mthr, mbusy, mcthr;
    int mcnt;
    logic [DW-1:0] f0 [D];

    always #5 clk = ~clk;

    rrf_mt #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .NREAD(NR), .NWRITE(NW)) dut (
        .clk(clk), .rst(rst),
        .read_clkEn(read_clkEn), .read_addr(ra), .read_oe(roe), .read_thread(rthr),
        .read_data(read_data),
        .write_addr(wa), .write_data(wd), .write_wen(wen), .write_thread(wthr),
        .clear_req(clear_req), .clear_thread(clear_thread), .clear_busy(clear_busy)
    );

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] q(input int p);
        return read_data[p*DW +: DW];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        wen = '0;
        clear_req = 0;
        read_clkEn = 0;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d, input logic t);
        wen[p] = 1'b1;
        wa[p*AW +: AW] = AW'(a);
        wd[p*DW +: DW] = d;
        wthr = t;
    endtask

    task automatic rd(input int p, input int a, input logic oe);
        ra[p*AW +: AW] = AW'(a);
        roe[p] = oe;
        read_clkEn = 1'b1;
    endtask

    always @(posedge rst) begin
        for (int b = 0; b < 2; b++)
            for (int e = 0; e < D; e++)
                m[b][e] = '0;
        for (int i = 0; i < NR; i++) mra[i] = 0;
        moe = '0;
        mthr = 0;
        mbusy = 0;
        mcthr = 0;
        mcnt = 0;
    end

    // Model: each entry's value after this cycle's writes is what a read sees now
    // and what the bank holds after the next edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) chk($sformatf("rst_rd%0d", i), q(i), '0);
            chk("rst_busy", 32'(clear_busy), 0);
        end else begin
            nxt = m;
            if (mbusy) nxt[mcthr][mcnt] = '0;
            for (int p = 0; p < NW; p++)
                if (wen[p] && int'(wa[p*AW +: AW]) < D) nxt[wthr][wa[p*AW +: AW]] = wd[p*DW +: DW];
            for (int i = 0; i < NR; i++)
                chk($sformatf("rd%0d", i), q(i), (moe[i] && mra[i] < D) ? nxt[mthr][mra[i]] : '0);
            chk("busy", 32'(clear_busy), 32'(mbusy));
            m = nxt;
            if (mbusy) begin
                if (mcnt == D - 1) mbusy = 0;
                else mcnt++;
            end else if (clear_req) begin
                mbusy = 1;
                mcthr = clear_thread;
                mcnt = 0;
            end
            if (read_clkEn) begin
                for (int i = 0; i < NR; i++) mra[i] = int'(ra[i*AW +: AW]);
                moe = roe;
                mthr = rthr;
            end
        end
    end

    initial begin
        int n;
        logic [DW-1:0] v;
        logic sm;
        #2 rst = 1;
        repeat (3) tick;
        rst = 0;
        #1;
        for (int i = 0; i < NR; i++) chk("reset_rd", q(i), 0);
        chk("reset_busy", 32'(clear_busy), 0);
        for (int t = 0; t < 2; t++)
            for (int b = 0; b < D; b += NR) begin
                for (int p = 0; p < NR; p++) rd(p, (b + p) % D, 1);
                rthr = 1'(t);
                tick;
                #1;
                for (int p = 0; p < NR; p++) chk("reset_entry", q(p), 0);
            end

        wr(2, 3, 32'h5A, 0);
        tick;
        rd(0, 3, 1);
        rthr = 0;
        tick;
        #1;
        chk("wr_rd_t0", q(0), 32'h5A);
        rd(0, 3, 1);
        rthr = 1;
        tick;
        #1;
        chk("wr_rd_t1", q(0), 0);

        rd(5, 7, 1);
        rthr = 0;
        tick;
        wr(1, 7, 32'h11, 0);
        wr(4, 7, 32'h44, 0);
        #1;
        chk("bypass", q(5), 32'h44);
        tick;
        #1;
        chk("collide_store", q(5), 32'h44);

        for (int b = 0; b < D; b += NW) begin
            for (int p = 0; p < NW; p++)
                if (b + p < D) begin
                    v = $urandom | 1;
                    f0[b + p] = v;
                    wr(p, b + p, v, 0);
                end
            tick;
            for (int p = 0; p < NW; p++)
                if (b + p < D) wr(p, b + p, $urandom | 1, 1);
            tick;
        end
        clear_req = 1;
        clear_thread = 1;
        tick;
        n = 0;
        while (clear_busy && n < 200) begin
            n++;
            tick;
        end
        chk("clear_len", 32'(n), 32'(D));
        for (int b = 0; b < D; b += NR) begin
            for (int p = 0; p < NR; p++) rd(p, (b + p) % D, 1);
            rthr = 1;
            tick;
            #1;
            for (int p = 0; p < NR; p++) chk("clear_t1", q(p), 0);
        end
        for (int p = 0; p < NR; p++) rd(p, p, 1);
        rthr = 0;
        tick;
        #1;
        for (int p = 0; p < NR; p++) chk("keep_t0", q(p), f0[p]);

        clear_req = 1;
        clear_thread = 1;
        tick;
        n = 0;
        while (clear_busy && n < 200) begin
            n++;
            if (n == 11) begin
                wr(0, 5, 32'h99, 1);
                wr(3, 10, 32'h99, 1);
                clear_req = 1;
                clear_thread = 0;
            end
            tick;
        end
        chk("clear2_len", 32'(n), 32'(D));
        tick;
        #1;
        chk("no_retrigger", 32'(clear_busy), 0);
        rd(0, 5, 1);
        rd(1, 10, 1);
        rd(2, 11, 1);
        rthr = 1;
        tick;
        #1;
        chk("ovl_below", q(0), 32'h99);
        chk("ovl_at", q(1), 32'h99);
        chk("ovl_after", q(2), 0);
        rd(0, 0, 1);
        rthr = 0;
        tick;
        #1;
        chk("t0_kept", q(0), f0[0]);

        roe = '0;
        rd(0, D, 1);
        rd(1, 3, 0);
        rthr = 0;
        tick;
        #1;
        chk("addr_oob", q(0), 0);
        chk("oe_off", q(1), 0);
        rd(2, 9, 1);
        tick;
        #1;
        chk("hold_cap", q(2), f0[9]);
        ra[2*AW +: AW] = 10;
        roe[2] = 0;
        rthr = 1;
        tick;
        #1;
        chk("hold", q(2), f0[9]);

        clear_req = 1;
        clear_thread = 0;
        tick;
        repeat (5) tick;
        rst = 1;
        #1;
        chk("rst_midclear", 32'(clear_busy), 0);
        tick;
        rst = 0;
        #1;
        for (int p = 0; p < NR; p++) chk("post_rst", q(p), 0);

        repeat (2000) begin
            sm = 1'($urandom_range(0, 1));
            for (int p = 0; p < NW; p++)
                if ($urandom_range(0, 3) == 0)
                    wr(p, sm ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63)), $urandom, 0);
            wthr = 1'($urandom_range(0, 1));
            for (int i = 0; i < NR; i++) begin
                ra[i*AW +: AW] = sm ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 63));
                roe[i] = 1'($urandom_range(0, 1));
            end
            read_clkEn = 1'($urandom_range(0, 1));
            rthr = 1'($urandom_range(0, 1));
            clear_req = $urandom_range(0, 59) == 0;
            clear_thread = 1'($urandom_range(0, 1));
            tick;
        end
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rrf_mt.md
RRF_MT -- requirements
Module: rrf_mt

Parameters
REQ-001 DATA_WIDTH, default `alu_width, width of one register entry.
REQ-002 DEPTH, default 48, entries per thread bank (2..64).
REQ-003 ADDR_WIDTH, default 6, address width; DEPTH SHALL be <= 2**ADDR_WIDTH.
REQ-004 NREAD, default 9, read port count (1..12).
REQ-005 NWRITE, default 9, write port count (1..12).

Interface
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 read_clkEn  in  1  read-address stage capture enable.
REQ-009 read_addr  in  NREAD*ADDR_WIDTH  read addresses; port i at slice i.
REQ-010 read_oe  in  NREAD  per-port output enable.
REQ-011 read_thread  in  1  thread bank selected for all reads.
REQ-012 read_data  out  NREAD*DATA_WIDTH  read data; port i at slice i.
REQ-013 write_addr  in  NWRITE*ADDR_WIDTH  write addresses.
REQ-014 write_data  in  NWRITE*DATA_WIDTH  write data.
REQ-015 write_wen  in  NWRITE  per-port write enable.
REQ-016 write_thread  in  1  thread bank for all writes this cycle.
REQ-017 clear_req  in  1  one-cycle pulse; start bank clear.
REQ-018 clear_thread  in  1  bank to clear; sampled with clear_req.
REQ-019 clear_busy  out  1  high while clear sequence runs.

Function
REQ-020 Storage SHALL be 2 banks (thread 0/1) x DEPTH entries x DATA_WIDTH; read_thread and write_thread SHALL both select banks.
REQ-021 When read_clkEn=1, the module SHALL register read_addr, read_oe and read_thread; when read_clkEn=0, the registered values SHALL hold.
REQ-022 read_data port i SHALL combinationally reflect the bank/entry selected by the registered address; latency is 1 cycle from capture.
REQ-023 If registered oe_i=0 or registered address >= DEPTH, read_data port i SHALL be all zeros; outputs are never tri-stated.
REQ-024 Bypass: if a write hits the same bank and entry as a registered read address in the current cycle, read_data SHALL show that write's data in the same cycle.
REQ-025 A write SHALL update the entry at the next rising edge; writes with address >= DEPTH SHALL be ignored.
REQ-026 When multiple ports write the same entry in one cycle, the highest-index port SHALL win, for both storage and bypass.
REQ-027 FSM states are IDLE and CLEAR; reset state is IDLE.
REQ-028 IDLE with clear_req=1: capture clear_thread, set counter to 0, enter CLEAR; clear_busy SHALL rise the next cycle.
REQ-029 In CLEAR, each cycle SHALL zero entry counter of the captured bank and then increment the counter; after writing entry DEPTH-1, the FSM SHALL return to IDLE and drop clear_busy, giving exactly DEPTH busy cycles.
REQ-030 clear_req while in CLEAR SHALL be ignored.
REQ-031 A port write to the same entry the clear writes in that cycle SHALL win; port writes to entries already cleared SHALL persist.
REQ-032 Bypass SHALL also apply to clear writes, so a read of the entry being cleared returns 0 that cycle unless a port write wins.
REQ-033 Ports and the clear sequence SHALL have no effect on the bank that is not being written.

Reset
REQ-034 rst=1 SHALL asynchronously zero all entries in both banks.
REQ-035 rst=1 SHALL zero the registered addresses, registered oe and registered thread, so read_data=0.
REQ-036 rst=1 SHALL set the FSM to IDLE, the counter to 0 and clear_busy to 0, including mid-clear.

Verification
REQ-037 Reset: assert rst and release it -> all read_data=0 and clear_busy=0; a read of any entry in either bank returns 0.
REQ-038 Write/read: write 0x5A to T0 entry 3 via port 2; next cycle read port 0 with addr 3, oe=1, T0 -> 0x5A one cycle after capture; the same read on T1 -> 0.
REQ-039 Collision and bypass: ports 1 and 4 write entry 7 with 0x11 and 0x44 while read port 5 holds registered addr 7 -> same-cycle read_data=0x44, and stored value 0x44.
REQ-040 Clear: fill T1 with nonzero data and pulse clear_req with clear_thread=1 -> clear_busy is high for exactly DEPTH cycles, T1 reads all 0, and T0 is unchanged.
REQ-041 Clear overlap: during CLEAR, write 0x99 to an entry in the clear bank whose index is below the counter, and another at the counter index -> both read 0x99 after the clear; a second clear_req while busy is ignored.
REQ-042 Edge cases: read address DEPTH, oe=0, and read_clkEn=0 hold -> zeros, zeros, and a held prior value; rst mid-clear -> clear_busy=0 immediately.
